// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, key map and reset constants for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Entry {row, col} holds the legend value; row 3 carries E(*) 0 F(#) D.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] KEY_BLANK = 4'b0000;

    function automatic logic [3:0] key_value(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchroniser for the asynchronous row returns
module keypad_sync (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Idle rows are pulled up, so reset to "no key".
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, debounce and encode; KEYPAD_AUTOREPEAT_EN adds held-key repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       VALID,
    output logic       PRESSED
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [1:0] S_SCAN     = ST_SCAN;
    localparam logic [1:0] S_DEBOUNCE = ST_DEBOUNCE;
    localparam logic [1:0] S_PRESSED  = ST_PRESSED;
    localparam logic [1:0] S_RELEASE  = ST_RELEASE;

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          pressed_q, pressed_d;
    logic [3:0]    row_sync;
    logic          tick_end, row_low, any_low, accept, release_done;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep_q, rep_d;
`else
    localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

    keypad_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (ROW),
        .q   (row_sync)
    );

    assign tick_end = (tick_q == TW'(SCAN_DIV - 1));
    assign row_low  = !row_sync[row_idx_q];
    assign any_low  = (row_sync != 4'b1111);

    // All FSM decisions use the row sample taken on the last cycle of a tick.
    always_comb begin
        tick_d       = tick_end ? '0 : tick_q + TW'(1);
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        valid_d      = 1'b0;
        pressed_d    = pressed_q;
        accept       = 1'b0;
        release_done = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d        = rep_q;
`endif
        if (tick_end) begin
            case (state_q)
                S_SCAN: begin
                    if (any_low) begin
                        row_idx_d = lowest_low(row_sync);
                        if (DEBOUNCE_TICKS <= 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!row_low) begin
                        state_d   = S_SCAN;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (cnt_q >= CW'(DEBOUNCE_TICKS - 1)) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PRESSED: begin
                    if (!row_low) begin
                        if (DEBOUNCE_TICKS <= 1) begin
                            release_done = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = CW'(1);
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
                    end else if (rep_q == RW'(REPEAT_TICKS - 1)) begin
                        rep_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + RW'(1);
`endif
                    end
                end
                default: begin
                    if (row_low) begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (cnt_q >= CW'(DEBOUNCE_TICKS - 1)) begin
                        release_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
        if (accept) begin
            state_d   = S_PRESSED;
            cnt_d     = '0;
            key_d     = ~key_value(row_idx_d, col_idx_q);
            valid_d   = 1'b1;
            pressed_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d     = '0;
`endif
        end
        if (release_done) begin
            state_d   = S_SCAN;
            cnt_d     = '0;
            pressed_d = 1'b0;
            col_idx_d = col_idx_q + 2'd1;
        end
        col_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q    <= '0;
            state_q   <= S_SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            col_q     <= COL_RESET;
            key_q     <= KEY_BLANK;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            tick_q    <= tick_d;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign COL     = col_q;
    assign KEY     = key_q;
    assign VALID   = valid_q;
    assign PRESSED = pressed_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and produces the 4-bit active-low digit code consumed by the seven-segment display driver, so a key press lights the matching digit. It drives one column low at a time, synchronises and debounces the row returns, and encodes the pressed key. It issues a one-cycle `VALID` strobe per accepted press. It sits between the board keypad pins and the display/controller logic.

## Interface
- `SCAN_DIV`, 1000: clock cycles per column slot (one "tick"); minimum 4.
- `DEBOUNCE_TICKS`, 8: consecutive matching ticks required to accept a press or a release; minimum 1.
- `REPEAT_TICKS`, 200: held-key repeat interval in ticks; used only with the repeat feature.
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `ROW` input 4: keypad row returns, active-low, externally pulled up, asynchronous to `CLK`.
- `COL` output 4: column drive, active-low, exactly one bit low at any time.
- `KEY` output 4: code of the last accepted key, as the bitwise inverse of the key value (key 0 gives 4'b1111, key 9 gives 4'b0110).
- `VALID` output 1: one-cycle strobe; `KEY` is new in the same cycle.
- `PRESSED` output 1: high while an accepted key is held.

## Operation
- Reset values: `COL`=4'b1110, `KEY`=4'b0000 (blank on the display), `VALID`=0, `PRESSED`=0, all counters 0, state SCAN.
- `ROW` passes through a two-flop synchroniser. "Sample" means the synchronised `ROW` captured on the last cycle of a tick.
- Key value is map[row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- `KEY` = ~value.
- States:
  - **SCAN**: `COL` = ~(1<<col_idx).
    - Sample with no low bit: col_idx advances modulo 4 (3 wraps to 0).
    - Sample with any low bit: latch col_idx and the lowest-index low row. Go to DEBOUNCE with cnt=1 (with `DEBOUNCE_TICKS`=1, go directly to PRESSED).
  - **DEBOUNCE**: column frozen.
    - Each tick where the latched row is low: cnt+1.
    - Latched row high at any tick: cnt=0, col_idx+1, return to SCAN.
    - cnt reaching `DEBOUNCE_TICKS`: go to PRESSED. `KEY` loads, `VALID`=1 for that one cycle, `PRESSED`=1.
  - **PRESSED**:
    - Latched row high at a sample: go to RELEASE with cnt=1.
    - Latched row low: stay.
    - Other rows in the same column are ignored.
  - **RELEASE**:
    - Latched row high: cnt+1.
    - Latched row low: cnt=0, back to PRESSED, no new `VALID`.
    - cnt reaching `DEBOUNCE_TICKS`: `PRESSED`=0, col_idx+1, go to SCAN.
- Keys in other columns are invisible while a key is held. Release and re-scan are required before they can be accepted.
- `RST` asserted in any state returns all registers to reset values immediately. A partially debounced press is discarded.

## Timing
- Tick counter runs 0..`SCAN_DIV`-1 continuously. A column change occurs on the cycle after a tick end.
- The synchroniser adds 2 cycles. `SCAN_DIV`>=4 guarantees the row settles within the slot.
- Press latency, stable contact to `VALID`: at most 4·`SCAN_DIV` + `DEBOUNCE_TICKS`·`SCAN_DIV` + 2 cycles. It is at least `DEBOUNCE_TICKS`·`SCAN_DIV` cycles.
- Release latency, contact open to `PRESSED` low: at most (`DEBOUNCE_TICKS`+1)·`SCAN_DIV` + 2 cycles.
- Outputs are registered. `KEY` holds its value until the next accepted press.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter counts ticks.
  - Every `REPEAT_TICKS` ticks held, `VALID` pulses again with `KEY` unchanged.
  - The counter clears on entering PRESSED and on entering RELEASE. A return from RELEASE to PRESSED restarts the interval.
- Not defined: exactly one `VALID` per accepted press. The repeat counter and `REPEAT_TICKS` logic are absent.

## Structure
- Package `keypad_pkg`:
  - state enum (SCAN, DEBOUNCE, PRESSED, RELEASE)
  - 16-entry key map constant
  - `COL_RESET`=4'b1110
  - `KEY_BLANK`=4'b0000
- Sub-module `keypad_sync`: 4-bit two-flop synchroniser, `CLK`/`RST`, reset output 4'b1111.

## Test plan
Use `SCAN_DIV`=8, `DEBOUNCE_TICKS`=3, `REPEAT_TICKS`=4.
- **Reset:** hold `RST`=0 mid-run. Require `COL`=1110, `KEY`=0000, `VALID`=0 and `PRESSED`=0 asynchronously, before the next clock edge.
- **Clean press:** press key 5 (ROW[1] low while COL[1] low) for 200 cycles. Require one `VALID`, `KEY`=4'b1010 and `PRESSED`=1. After release, require `PRESSED`=0 within 34 cycles.
- **Bounce:** ROW[1] low for 2 ticks, then high. Require no `VALID`, `KEY` unchanged and scanning resumed.
- **Simultaneous keys:** press keys 1 and 7 (rows 0 and 2, column 0). Require `KEY`=~1=4'b1110.
- **Glitchy release and reset mid-press:**
  - A release glitch of 1 tick while held gives no second `VALID`.
  - Asserting `RST` during DEBOUNCE gives no `VALID` after reset releases if the key is already removed.
- **Autorepeat:** with `KEYPAD_AUTOREPEAT_EN`, hold key 0. Require `VALID` at acceptance, then every 32 cycles, with `KEY`=4'b1111. Without the macro, require a single `VALID`.
